// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: round-robin owner of the VGA pixel-write port with locked bursts.
// Define VGA_ARB_CLIP_EN to drop writes outside X_LIMIT/Y_LIMIT.
module vga_write_arbiter #(
    parameter int NREQ        = 3,
    parameter int nX          = 10,
    parameter int nY          = 9,
    parameter int COLOR_DEPTH = 9,
    parameter int MAX_BURST   = 16,
    parameter int X_LIMIT     = 640,
    parameter int Y_LIMIT     = 480
) (
    input  logic                        Clock,
    input  logic                        Resetn,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ-1:0]             lock,
    input  logic [NREQ*nX-1:0]          x_in,
    input  logic [NREQ*nY-1:0]          y_in,
    input  logic [NREQ*COLOR_DEPTH-1:0] color_in,
    output logic [NREQ-1:0]             gnt,
    output logic [nX-1:0]               VGA_x,
    output logic [nY-1:0]               VGA_y,
    output logic [COLOR_DEPTH-1:0]      VGA_color,
    output logic                        VGA_write,
    output logic [2:0]                  owner,
    output logic                        locked
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t                 state, state_nx;
    logic [2:0]             ptr, ptr_nx, owner_nx;
    logic [7:0]             burst_cnt, cnt_nx, cnt_inc;
    logic [7:0]             req_x, lock_x, gnt_full;
    logic [2:0]             cand, rr_idx, gidx;
    logic                   rr_hit, own_hold, accept, clip;
    logic [nX-1:0]          sel_x;
    logic [nY-1:0]          sel_y;
    logic [COLOR_DEPTH-1:0] sel_c;

    assign req_x  = 8'(req);
    assign lock_x = 8'(lock);

    // Round-robin search starting one past the last accepted requester
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        cand   = '0;
        for (int n = 1; n <= NREQ; n++) begin
            cand = 3'((int'(ptr) + n) % NREQ);
            if (!rr_hit && req_x[cand]) begin
                rr_hit = 1'b1;
                rr_idx = cand;
            end
        end
    end

    // Mux the granted requester's pixel onto the shared datapath
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == gidx) begin
                sel_x = x_in[i*nX +: nX];
                sel_y = y_in[i*nY +: nY];
                sel_c = color_in[i*COLOR_DEPTH +: COLOR_DEPTH];
            end
        end
    end

`ifdef VGA_ARB_CLIP_EN
    assign clip = (32'(sel_x) >= X_LIMIT) || (32'(sel_y) >= Y_LIMIT);
`else
    // Limits are positive, so this is a constant zero: no clipping
    assign clip = (X_LIMIT < 0) && (Y_LIMIT < 0);
`endif

    // State register: FSM state plus pointer, owner and burst count
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= IDLE;
            ptr       <= 3'(NREQ - 1);
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            owner     <= owner_nx;
            burst_cnt <= cnt_nx;
        end
    end

    // Next state: hold the owner while it keeps requesting, else re-arbitrate
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        owner_nx = owner;
        cnt_nx   = burst_cnt;
        cnt_inc  = (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;
        if (own_hold) begin
            cnt_nx = cnt_inc;
            if (!lock_x[owner] || cnt_inc >= 8'(MAX_BURST))
                state_nx = IDLE;
        end else begin
            state_nx = IDLE;
            if (rr_hit) begin
                ptr_nx = rr_idx;
                if (lock_x[rr_idx] && MAX_BURST > 1) begin
                    state_nx = OWN;
                    owner_nx = rr_idx;
                    cnt_nx   = 8'd1;
                end
            end
        end
    end

    // Outputs: combinational grant, forced low while reset is held
    always_comb begin
        own_hold = (state == OWN) && req_x[owner];
        gidx     = own_hold ? owner : rr_idx;
        accept   = Resetn && (own_hold || rr_hit);
        gnt_full = accept ? (8'd1 << gidx) : 8'd0;
        gnt      = gnt_full[NREQ-1:0];
        locked   = (state == OWN);
    end

    // Registered pixel bundle to the adapter; one write pulse per kept accept
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            VGA_x     <= '0;
            VGA_y     <= '0;
            VGA_color <= '0;
            VGA_write <= 1'b0;
        end else begin
            VGA_write <= accept && !clip;
            if (accept && !clip) begin
                VGA_x     <= sel_x;
                VGA_y     <= sel_y;
                VGA_color <= sel_c;
            end
        end
    end

endmodule
